// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix streaming blocks: default geometry,
// the transpose FSM state encoding and a flat-buffer index helper.
package matrix_pkg;

  localparam int MATRIX_DATA_WIDTH = 9;
  localparam int MATRIX_MAX_DIM    = 5;
  localparam int MATRIX_DIM_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } mt_state_e;

  // Row-major position of [row][col] in a square buffer of side 'stride'.
  function automatic int flat_index(input int row, input int col, input int stride);
    return row * stride + col;
  endfunction

endpackage

// File: rtl/rc_counter.sv
// Two-level index counter: col runs 0..col_lim-1, then wraps and advances row.
// 'last' flags the final position of the row_lim x col_lim walk.
module rc_counter
  import matrix_pkg::*;
#(
  parameter int DIM_W = MATRIX_DIM_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIM_W-1:0] row_lim,
  input  logic [DIM_W-1:0] col_lim,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic             last
);

  logic col_wrap;

  assign col_wrap = (col == col_lim - DIM_W'(1));
  assign last     = col_wrap && (row == row_lim - DIM_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col <= '0;
        row <= last ? '0 : row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_transpose_stream.sv
// Streaming matrix transpose: loads an r x c row-major stream into a register
// buffer, then replays it column-major as a c x r row-major stream.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for a start with in-range dimensions
//   ST_LOAD  | accepting r*c source elements into the buffer
//   ST_DRAIN | emitting transposed elements through the output register
module matrix_transpose_stream
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
  parameter int MAX_DIM    = MATRIX_MAX_DIM,
  parameter int DIM_W      = MATRIX_DIM_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIM_W-1:0]      r_in,
  input  logic [DIM_W-1:0]      c_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [DIM_W-1:0]      r_out,
  output logic [DIM_W-1:0]      c_out,
  output logic                  busy,
  output logic                  err
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mt_state_e state_q, state_d;

  logic [DIM_W-1:0]      r_q, c_q;
  logic [DATA_WIDTH-1:0] buf_q [DEPTH];

  logic [DIM_W-1:0] ld_row, ld_col, dr_row, dr_col;
  logic             ld_last, dr_last;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  logic dims_ok, start_acc, start_rej;
  logic in_fire, out_fire, out_load;

  assign dims_ok = (r_in != '0) && (r_in <= DIM_W'(MAX_DIM)) &&
                   (c_in != '0) && (c_in <= DIM_W'(MAX_DIM));

  // Abort outranks everything, so every qualifier below is gated by it.
  assign start_acc = (state_q == ST_IDLE) && start && !abort && dims_ok;
  assign start_rej = (state_q == ST_IDLE) && start && !abort && !dims_ok;
  assign in_fire   = (state_q == ST_LOAD) && in_valid && !abort;
  assign out_fire  = out_valid && out_ready && !abort;

  // Reload the output register when it is empty (first drain cycle) or when
  // a non-final element leaves it.
  assign out_load = (state_q == ST_DRAIN) && !abort &&
                    (!out_valid || (out_ready && !out_last));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_acc) state_d = ST_LOAD;
        ST_LOAD:  if (in_fire && ld_last) state_d = ST_DRAIN;
        ST_DRAIN: if (out_fire && out_last) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
      c_q <= '0;
      err <= 1'b0;
    end else begin
      err <= start_rej;
      if (start_acc) begin
        r_q <= r_in;
        c_q <= c_in;
      end
    end
  end

  assign r_out = c_q;
  assign c_out = r_q;

  // Load walk: row over r, col over c.
  rc_counter #(.DIM_W(DIM_W)) u_load_idx (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_acc || abort),
    .en      (in_fire),
    .row_lim (r_q),
    .col_lim (c_q),
    .row     (ld_row),
    .col     (ld_col),
    .last    (ld_last)
  );

  // Drain walk: row is the source column i (over c), col is the source row j
  // (over r), so j runs fastest.
  rc_counter #(.DIM_W(DIM_W)) u_drain_idx (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_acc || abort),
    .en      (out_load),
    .row_lim (c_q),
    .col_lim (r_q),
    .row     (dr_row),
    .col     (dr_col),
    .last    (dr_last)
  );

  assign wr_idx = IDX_W'(flat_index(int'(ld_row), int'(ld_col), MAX_DIM));
  assign rd_idx = IDX_W'(flat_index(int'(dr_col), int'(dr_row), MAX_DIM));

  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_q[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (abort) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out_last  <= dr_last;
      out_data  <= buf_q[rd_idx];
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Directed bench for matrix_transpose_stream: a transpose model fills a
// scoreboard at start time, and each output transfer is popped and compared.
module tb_matrix_transpose_stream;
   import matrix_pkg::*;

   localparam int DW    = 9;
   localparam int MD    = 5;
   localparam int DIM_W = 3;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start, abort;
   logic [DIM_W-1:0] r_in, c_in, r_out, c_out;
   logic             in_valid, in_ready;
   logic [DW-1:0]    in_data, out_data;
   logic             out_valid, out_ready, out_last;
   logic             busy, err;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t sb[$];
   int   src[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   matrix_transpose_stream #(
      .DATA_WIDTH (DW),
      .MAX_DIM    (MD),
      .DIM_W      (DIM_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .r_in      (r_in),
      .c_in      (c_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .r_out     (r_out),
      .c_out     (c_out),
      .busy      (busy),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic fill_src(input int base, input int n);
      src.delete();
      for (int k = 0; k < n; k++) src.push_back(base + k);
   endtask

   // Transposed order: element (i, j) of the result is source [j][i].
   task automatic build_sb(input int r, input int c);
      exp_t e;
      sb.delete();
      for (int i = 0; i < c; i++) begin
         for (int j = 0; j < r; j++) begin
            e.data = DW'(src[j * c + i]);
            e.last = (i == c - 1) && (j == r - 1);
            sb.push_back(e);
         end
      end
   endtask

   task automatic do_start(input int r, input int c);
      start = 1'b1;
      r_in  = DIM_W'(r);
      c_in  = DIM_W'(c);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic feed(input int n);
      for (int k = 0; k < n; k++) begin
         for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
         chk("in_ready", in_ready, 1'b1);
         in_valid = 1'b1;
         in_data  = DW'(src[k]);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   // Called on the negedge right after the last input was accepted.
   task automatic check_latency();
      chk("drain_entry_valid", out_valid, 1'b0);
      chk("drain_entry_busy", busy, 1'b1);
      @(negedge clk);
      chk("first_valid", out_valid, 1'b1);
   endtask

   // mode 0: out_ready held high; mode 1: out_ready toggles every cycle.
   task automatic drain(input int mode, input int n);
      int            got = 0;
      logic          prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      logic          prev_last = 1'b0;
      exp_t          e;
      for (int cyc = 0; cyc < 300 && got < n; cyc++) begin
         out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
         end
         if (mode == 0 && got > 0) chk("no_bubble", out_valid, 1'b1);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("extra_output", out_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               chk("out_data", out_data, e.data);
               chk("out_last", out_last, e.last);
            end
            got++;
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("drain_count", got, n);
   endtask

   task automatic check_idle_after();
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("sb_empty", sb.size(), 0);
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      r_in      = '0;
      c_in      = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_data", out_data, 9'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_r_out", r_out, 3'd0);
      chk("rst_c_out", c_out, 3'd0);

      // 2x3 with start on the first edge after reset release.
      reset_n = 1'b1;
      fill_src(1, 6);
      build_sb(2, 3);
      do_start(2, 3);
      chk("r_out_2x3", r_out, 3'd3);
      chk("c_out_2x3", c_out, 3'd2);
      chk("busy_2x3", busy, 1'b1);
      feed(6);
      check_latency();
      drain(0, 6);
      check_idle_after();

      // 5x5 with output backpressure every other cycle.
      fill_src(0, 25);
      build_sb(5, 5);
      do_start(5, 5);
      feed(25);
      check_latency();
      drain(1, 25);
      check_idle_after();

      // Rejected starts: zero and oversized dimensions.
      do_start(0, 3);
      chk("err_r0", err, 1'b1);
      chk("err_r0_busy", busy, 1'b0);
      chk("err_r0_r_out", r_out, 3'd5);
      chk("err_r0_c_out", c_out, 3'd5);
      @(negedge clk);
      chk("err_pulse_end", err, 1'b0);
      do_start(6, 1);
      chk("err_r6", err, 1'b1);
      chk("err_r6_busy", busy, 1'b0);
      chk("err_r6_r_out", r_out, 3'd5);
      @(negedge clk);
      chk("err_r6_end", err, 1'b0);

      // 1x1.
      src.delete();
      src.push_back('h1AB);
      build_sb(1, 1);
      do_start(1, 1);
      feed(1);
      check_latency();
      chk("single_last", out_last, 1'b1);
      drain(0, 1);
      check_idle_after();

      // 3x3 aborted after 4 inputs; a start while busy is ignored.
      fill_src(100, 9);
      do_start(3, 3);
      feed(4);
      do_start(1, 1);
      chk("busy_start_err", err, 1'b0);
      chk("busy_start_r_out", r_out, 3'd3);
      chk("busy_start_busy", busy, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_in_ready", in_ready, 1'b0);
      chk("abort_out_valid", out_valid, 1'b0);

      fill_src(7, 4);
      build_sb(2, 2);
      chk("model_order", sb[1].data, 9'd9);
      do_start(2, 2);
      feed(4);
      check_latency();
      drain(0, 4);
      check_idle_after();

      // 4x2 interrupted by reset mid-drain.
      fill_src('h40, 8);
      build_sb(4, 2);
      do_start(4, 2);
      feed(8);
      check_latency();
      drain(0, 3);
      chk("mid_drain_valid", out_valid, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_out_valid", out_valid, 1'b0);
      chk("async_out_last", out_last, 1'b0);
      chk("async_out_data", out_data, 9'd0);
      chk("async_busy", busy, 1'b0);
      chk("async_in_ready", in_ready, 1'b0);
      chk("async_r_out", r_out, 3'd0);
      chk("async_c_out", c_out, 3'd0);
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;

      fill_src('h155, 4);
      build_sb(2, 2);
      do_start(2, 2);
      feed(4);
      check_latency();
      drain(0, 4);
      check_idle_after();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
